// File: rtl/rv32_pkg.sv
// Shared RV32 front-end definitions: control-flow opcodes, the next-PC
// select encoding and the B/J immediate extractors.
package rv32_pkg;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   // Listed in priority order, highest first.
   typedef enum logic [1:0] {
      PC_JALR_EX,
      PC_ADDER_ID,
      PC_HOLD,
      PC_SEQ
   } pc_sel_t;

   function automatic logic [31:0] imm_b(input logic [31:0] i);
      return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] i);
      return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/pc_next_unit_if.sv
// Bus between the ID/EX pipeline control and pc_next_unit.
//   master : pipeline side, drives stall/ID instruction/EX result, reads PCs.
//   slave  : pc_next_unit itself.
interface pc_next_unit_if #(
   parameter int CNT_WIDTH = 32
);
   logic                 stall_i;
   logic [31:0]          instruction_id_i;
   logic [31:0]          pc_reg_id_i;
   logic                 branch_condition_i;
   logic [31:0]          alu_result_ex_i;
   logic                 id_ex_flush_i;
   logic [31:0]          pc_reg_if_o;
   logic [31:0]          pc_next_if_o;
   logic [31:0]          branch_adder_id_o;
   logic                 if_id_flush_o;
   logic                 id_ex_flush_o;
   logic                 jalr_ex_o;
   logic                 misaligned_o;
   logic [CNT_WIDTH-1:0] redirect_cnt_o;

   modport master (
      output stall_i, instruction_id_i, pc_reg_id_i, branch_condition_i,
             alu_result_ex_i, id_ex_flush_i,
      input  pc_reg_if_o, pc_next_if_o, branch_adder_id_o, if_id_flush_o,
             id_ex_flush_o, jalr_ex_o, misaligned_o, redirect_cnt_o
   );

   modport slave (
      input  stall_i, instruction_id_i, pc_reg_id_i, branch_condition_i,
             alu_result_ex_i, id_ex_flush_i,
      output pc_reg_if_o, pc_next_if_o, branch_adder_id_o, if_id_flush_o,
             id_ex_flush_o, jalr_ex_o, misaligned_o, redirect_cnt_o
   );

endinterface

// File: rtl/pc_sel_mux.sv
// Next-PC priority encoder. Pure combinational: picks the PC source and
// the flushes that accompany a redirect.
//   jalr_ex_i    : valid JALR in EX (highest priority)
//   stall_i      : ID held this cycle
//   jal_id_i     : JAL in ID
//   br_taken_i   : taken conditional branch in ID
//   pc_sel_o     : selected source
//   if_id_flush_o, id_ex_flush_o : flushes caused by the redirect
//   redirect_o   : a redirect (JALR or ID adder) was selected
module pc_sel_mux
   import rv32_pkg::*;
(
   input  logic    jalr_ex_i,
   input  logic    stall_i,
   input  logic    jal_id_i,
   input  logic    br_taken_i,
   output pc_sel_t pc_sel_o,
   output logic    if_id_flush_o,
   output logic    id_ex_flush_o,
   output logic    redirect_o
);

   always_comb begin
      pc_sel_o      = PC_SEQ;
      if_id_flush_o = 1'b0;
      id_ex_flush_o = 1'b0;
      redirect_o    = 1'b0;
      if (jalr_ex_i) begin
         // The ID instruction sits behind the JALR and is wrong-path too.
         pc_sel_o      = PC_JALR_EX;
         if_id_flush_o = 1'b1;
         id_ex_flush_o = 1'b1;
         redirect_o    = 1'b1;
      end else if (!stall_i && (jal_id_i || br_taken_i)) begin
         pc_sel_o      = PC_ADDER_ID;
         if_id_flush_o = 1'b1;
         redirect_o    = 1'b1;
      end else if (stall_i) begin
         pc_sel_o      = PC_HOLD;
      end
   end

endmodule

// File: rtl/pc_next_unit.sv
// IF program counter and next-PC selection. JAL/branches resolve in ID
// (one wrong-path fetch), JALR resolves in EX (two).
//   clk, reset : clock, asynchronous active-low reset
//   bus        : pc_next_unit_if slave (ID/EX inputs, PCs, flushes,
//                misalignment flag, saturating redirect counter)
module pc_next_unit
   import rv32_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          CNT_WIDTH = 32
) (
   input  logic           clk,
   input  logic           reset,
   pc_next_unit_if.slave  bus
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [31:0]          pc_reg_if_q, pc_next_d;
   logic                 jalr_ex_q, jalr_ex_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   logic [6:0]  opcode;
   logic        is_jal, is_jalr, is_br, br_taken;
   logic [31:0] imm, adder;
   pc_sel_t     pc_sel;
   logic        sel_if_id, sel_id_ex, redirect;
   logic        id_ex_flush;

   assign opcode   = bus.instruction_id_i[6:0];
   assign is_jal   = (opcode == OPC_JAL);
   assign is_jalr  = (opcode == OPC_JALR);
   assign is_br    = (opcode == OPC_BRANCH);
   assign imm      = is_br ? imm_b(bus.instruction_id_i) : imm_j(bus.instruction_id_i);
   assign adder    = bus.pc_reg_id_i + imm;
   // funct3[0] flips the comparator sense (BNE/BGE/BGEU).
   assign br_taken = is_br & (bus.instruction_id_i[12] ^ bus.branch_condition_i);

   pc_sel_mux u_sel (
      .jalr_ex_i     (jalr_ex_q),
      .stall_i       (bus.stall_i),
      .jal_id_i      (is_jal),
      .br_taken_i    (br_taken),
      .pc_sel_o      (pc_sel),
      .if_id_flush_o (sel_if_id),
      .id_ex_flush_o (sel_id_ex),
      .redirect_o    (redirect)
   );

   always_comb begin
      pc_next_d = pc_reg_if_q + 32'd4;
      unique case (pc_sel)
         PC_JALR_EX:  pc_next_d = bus.alu_result_ex_i;
         PC_ADDER_ID: pc_next_d = adder;
         PC_HOLD:     pc_next_d = pc_reg_if_q;
         default:     pc_next_d = pc_reg_if_q + 32'd4;
      endcase
      if (!reset) pc_next_d = RESET_PC;
   end

   // While reset is held both pipeline registers are killed.
   assign id_ex_flush = !reset | bus.id_ex_flush_i | sel_id_ex;
   assign jalr_ex_d   = is_jalr & !bus.stall_i & !id_ex_flush;
   assign cnt_d       = (redirect && !(&cnt_q)) ? cnt_q + CNT_ONE : cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_reg_if_q <= RESET_PC;
         jalr_ex_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         pc_reg_if_q <= pc_next_d;
         jalr_ex_q   <= jalr_ex_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.pc_reg_if_o       = pc_reg_if_q;
   assign bus.pc_next_if_o      = pc_next_d;
   assign bus.branch_adder_id_o = adder;
   assign bus.if_id_flush_o     = !reset | sel_if_id;
   assign bus.id_ex_flush_o     = id_ex_flush;
   assign bus.jalr_ex_o         = jalr_ex_q;
   assign bus.misaligned_o      = reset & redirect & pc_next_d[1];
   assign bus.redirect_cnt_o    = cnt_q;

endmodule
